// File: rtl/y_deser_pkg.sv
// -----------------------------------------------------------------------------
// y_deser_pkg
// Shared types and constants for the Y-stream deserializer.
//   state_t       : two-state FSM encoding (COLLECT, HOLD)
//   DEFAULT_WIDTH : default bits per output word
//   cnt_w()       : width of the bit counter for a given word width
// -----------------------------------------------------------------------------
package y_deser_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/y_deserializer.sv
// -----------------------------------------------------------------------------
// y_deserializer
// Packs WIDTH consecutive bits of the 1-bit Y stream, LSB first, into one
// parallel word and presents it on a registered enable/ready port. While a
// completed word waits for acceptance the serial input is back-pressured.
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_data    : serial bit (upstream Y_data)
//   in_enable  : in_data valid (upstream Y_enable)
//   in_ready   : bit can be accepted (upstream Y_ready), combinational
//   out_data   : assembled word, updated only on word completion
//   out_enable : out_data valid
//   out_ready  : consumer accepts the word
//   out_parity : XOR of all out_data bits (only with Y_DESER_PARITY_EN)
//   bit_cnt    : bits collected so far in the current word
//
// Build option: define Y_DESER_PARITY_EN to add the out_parity port.
// -----------------------------------------------------------------------------
module y_deserializer
    import y_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_data,
    input  logic                        in_enable,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_enable,
    input  logic                        out_ready,
`ifdef Y_DESER_PARITY_EN
    output logic                        out_parity,
`endif
    output logic [cnt_w(WIDTH)-1:0]     bit_cnt
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("y_deserializer: WIDTH must be in 2..32");
    end

    state_t             state;
    // Holds bits 0..WIDTH-2; the final bit goes straight into out_data.
    logic [WIDTH-2:0]   shreg;

    logic bit_xfer;
    logic word_xfer;
    logic word_done;

    // In HOLD the input may only move when the pending word leaves on the
    // same edge, which is what gives zero-bubble back-to-back words.
    assign in_ready  = (state == COLLECT) || out_ready;
    assign bit_xfer  = in_enable && in_ready;
    assign word_xfer = out_enable && out_ready;
    assign word_done = (state == COLLECT) && bit_xfer && (bit_cnt == LAST_BIT);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= COLLECT;
            out_data   <= '0;
            out_enable <= 1'b0;
            bit_cnt    <= '0;
            // NOTE: partial-word bits are don't-care, but this is a small flop
            // register rather than a memory, so clearing it costs nothing and
            // keeps simulation free of X.
            shreg      <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bit_xfer) begin
                        if (word_done) begin
                            out_data   <= {in_data, shreg};
                            out_enable <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= HOLD;
                        end else begin
                            shreg[bit_cnt] <= in_data;
                            bit_cnt        <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (word_xfer) begin
                        out_enable <= 1'b0;
                        state      <= COLLECT;
                        // A bit arriving with the hand-off starts the next word.
                        if (bit_xfer) begin
                            shreg[0] <= in_data;
                            bit_cnt  <= CNT_W'(1);
                        end else begin
                            bit_cnt  <= '0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef Y_DESER_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_parity <= 1'b0;
        end else if (word_done) begin
            out_parity <= ^{in_data, shreg};
        end
    end
`else
    // Parity build option disabled: no out_parity port or logic.
`endif

endmodule
